// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-block instruction cache with a two-state miss FSM.
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | serve hits with zero latency; latch the miss address on a miss
// FETCH | single-word memory read outstanding; install the word when iwait=0
module icache_dm #(
  parameter  int SETS  = 16,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [29:0]       miss_addr_q, miss_addr_d;

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  fill_idx;
  logic [TAG_W-1:0]  fill_tag;
  logic              hit;
  logic              fill;
  logic [1:0]        unused_byte_offset;

  assign req_idx            = imemaddr[IDX_W+1:2];
  assign req_tag            = imemaddr[31:IDX_W+2];
  assign fill_idx           = miss_addr_q[IDX_W-1:0];
  assign fill_tag           = miss_addr_q[29:IDX_W];
  assign unused_byte_offset = imemaddr[1:0];

  assign hit  = (state_q == IDLE) && imemREN && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill = (state_q == FETCH) && !iwait;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          state_d     = FETCH;
          miss_addr_d = imemaddr[31:2];
        end
      end
      FETCH: begin
        // The read is never aborted; address changes wait for the return to IDLE.
        if (!iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state_q)
      IDLE: begin
        ihit     = hit;
        imemload = hit ? data_q[req_idx] : '0;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_addr_q, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays need no reset: valid gates every use of them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (hit) hit_count_d = hit_count_q + 32'd1;
    if ((state_q == IDLE) && (state_d == FETCH)) miss_count_d = miss_count_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomized self-checking bench for icache_dm against an array-based cache model.
// Counter expectations follow ICACHE_STATS_EN the same way the design does.
module tb_icache_dm;
  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_dm #(.SETS(SETS)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  bit          m_valid [SETS];
  int unsigned m_tag   [SETS];
  logic [31:0] m_data  [SETS];
  int unsigned exp_hits   = 0;
  int unsigned exp_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic int unsigned m_index(input logic [31:0] a);
    return (a / 4) % SETS;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] a);
    return a / (4 * SETS);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_index(a)] && (m_tag[m_index(a)] == m_tagof(a));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hitcnt"}, hit_count, exp_hits);
    check({tag, "_misscnt"}, miss_count, exp_misses);
`else
    check({tag, "_hitcnt"}, hit_count, 32'd0);
    check({tag, "_misscnt"}, miss_count, 32'd0);
`endif
  endtask

  // One request; on a miss runs the whole fetch and then checks the re-presented hit.
  task automatic access(input logic [31:0] addr, input int waits, input logic [31:0] d,
                        input bit disturb, input logic [31:0] alt);
    logic [31:0] waddr;
    waddr    = addr & 32'hFFFF_FFFC;
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    iload    = $urandom;
    @(negedge CLK);
    if (m_hit(addr)) begin
      check("hit_ihit", ihit, 1'b1);
      check("hit_data", imemload, m_data[m_index(addr)]);
      check("hit_iren", iREN, 1'b0);
      exp_hits++;
      step();
      return;
    end
    check("miss_ihit", ihit, 1'b0);
    check("miss_iren", iREN, 1'b0);
    exp_misses++;
    step();
    for (int i = 0; i < waits; i++) begin
      iwait = 1'b1;
      if (disturb) begin
        imemaddr = alt;
        imemREN  = 1'($urandom_range(0, 1));
      end
      @(negedge CLK);
      check("wait_iren", iREN, 1'b1);
      check("wait_iaddr", iaddr, waddr);
      check("wait_ihit", ihit, 1'b0);
      check("wait_load", imemload, 32'd0);
      step();
    end
    iwait = 1'b0;
    iload = d;
    @(negedge CLK);
    check("ret_iren", iREN, 1'b1);
    check("ret_iaddr", iaddr, waddr);
    step();
    m_valid[m_index(addr)] = 1'b1;
    m_tag[m_index(addr)]   = m_tagof(addr);
    m_data[m_index(addr)]  = d;
    iwait    = 1'b1;
    iload    = $urandom;
    imemREN  = 1'b1;
    imemaddr = addr;
    @(negedge CLK);
    check("refill_ihit", ihit, 1'b1);
    check("refill_data", imemload, d);
    check("refill_iren", iREN, 1'b0);
    exp_hits++;
    step();
  endtask

  task automatic idle_cycle();
    imemREN  = 1'b0;
    imemaddr = $urandom;
    @(negedge CLK);
    check("idle_ihit", ihit, 1'b0);
    check("idle_load", imemload, 32'd0);
    check("idle_iren", iREN, 1'b0);
    check("idle_iaddr", iaddr, 32'd0);
    step();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, SETS - 1) << 2) | $urandom_range(0, 3);
    return a;
  endfunction

  initial begin
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    m_clear();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ihit", ihit, 1'b0);
    check("rst_load", imemload, 32'd0);
    check("rst_iren", iREN, 1'b0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_hitcnt", hit_count, 32'd0);
    check("rst_misscnt", miss_count, 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;

    access(32'h0000_0040, 2, 32'hDEAD_BEEF, 1'b0, 32'h0);
    access(32'h0000_0042, 0, 32'h0, 1'b0, 32'h0);
    check("cold_stats_misses", miss_count, 32'd0 + (hit_count != 0 ? 32'd1 : 32'd0));

    access(32'h0000_0000, 0, 32'h1111_1111, 1'b0, 32'h0);
    access(32'h0000_0040, 1, 32'h2222_2222, 1'b0, 32'h0);
    access(32'h0000_0000, 0, 32'h3333_3333, 1'b0, 32'h0);
    access(32'h0000_0040, 0, 32'h4444_4444, 1'b0, 32'h0);

    access(32'h0000_0100, 3, 32'hA5A5_0100, 1'b1, 32'h0000_0200);
    access(32'h0000_0200, 1, 32'hA5A5_0200, 1'b0, 32'h0);
    access(32'h0000_0100, 0, 32'h0, 1'b0, 32'h0);
    check_stats("directed");

    // Reset during an outstanding fetch.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0300;
    iwait    = 1'b1;
    step();
    @(negedge CLK);
    check("prerst_iren", iREN, 1'b1);
    check("prerst_iaddr", iaddr, 32'h0000_0300);
    #1 RST = 1'b1;
    #1;
    check("midrst_iren", iREN, 1'b0);
    check("midrst_iaddr", iaddr, 32'd0);
    m_clear();
    step();
    RST = 1'b0;
    check_stats("afterrst");

    access(32'h0000_0200, 0, 32'hC0DE_0200, 1'b0, 32'h0);
    access(32'h0000_0200, 0, 32'h0, 1'b0, 32'h0);
    access(32'h0000_0201, 0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
`ifdef ICACHE_STATS_EN
    check("stats_miss1", miss_count, 32'd1);
    check("stats_hit3", hit_count, 32'd3);
`else
    check("stats_miss0", miss_count, 32'd0);
    check("stats_hit0", hit_count, 32'd0);
`endif
    step();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      else access(rand_addr(), $urandom_range(0, 3), $urandom,
                  ($urandom_range(0, 3) == 0), rand_addr());
    end
    idle_cycle();
    check_stats("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
